// File: rtl/board_frame_rx.sv
// Serial receiver for one inter-board frame: start, DATA_BITS payload LSB-first,
// even-parity bit, stop. Good frames are held on data_out with a one-cycle ready strobe.
module board_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 650,
  parameter int unsigned DATA_BITS    = 162
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 ready,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned NumCells = DATA_BITS / 2;

  localparam logic [CW-1:0] HalfM1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FullM1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 parity_ok_q, parity_ok_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 cell_bad;
  logic                 tick_half, tick_full;

  assign tick_half = (clk_cnt_q == HalfM1);
  assign tick_full = (clk_cnt_q == FullM1);

  // A cell value of 2'b11 has no board meaning, so any occurrence rejects the frame.
  always_comb begin
    cell_bad = 1'b0;
    for (int unsigned k = 0; k < NumCells; k++) begin
      if (shift_q[2*k +: 2] == 2'b11) cell_bad = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    parity_ok_d = parity_ok_q;
    data_d      = data_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d   = StStart;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          par_acc_d = 1'b0;
        end
      end

      StStart: begin
        if (tick_half) begin
          clk_cnt_d = '0;
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (tick_full) begin
          shift_d[bit_cnt_q] = rx_s_q;
          par_acc_d          = par_acc_q ^ rx_s_q;
          clk_cnt_d          = '0;
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StParity: begin
        if (tick_full) begin
          parity_ok_d = (par_acc_q == rx_s_q);
          clk_cnt_d   = '0;
          state_d     = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (tick_full) begin
          clk_cnt_d = '0;
          if (!rx_s_q) begin
            // Line held low: report once, then wait out the break before re-arming.
            err_d   = 1'b1;
            state_d = StBreak;
          end else if (parity_ok_q && !cell_bad) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StBreak: begin
        if (rx_s_q) begin
          clk_cnt_d = '0;
          state_d   = StIdle;
        end
      end

      default: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      parity_ok_q <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      parity_ok_q <= parity_ok_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  assign data_out  = data_q;
  assign ready     = ready_q;
  assign frame_err = err_q;
  assign busy      = (state_q != StIdle);

endmodule
